// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard, forwarding and stage-enable control for the
// in-order MIPS pipeline, with its own tracker of in-flight producers.
module pipe_hazard_unit #(
  parameter int AW             = 5,
  parameter int DEPTH          = 3,
  parameter int LOAD_POS       = 2,
  parameter int STORE_LATE_FWD = 1,
  parameter int BR_BUBBLES     = 0,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [AW-1:0]    id_rs_addr,
  input  logic [AW-1:0]    id_rt_addr,
  input  logic             id_wen,
  input  logic [AW-1:0]    id_waddr,
  input  logic             id_is_load,
  input  logic             id_is_store,
  input  logic             branch_taken,
  input  logic             ext_stall,
  input  logic             debug_en,
  input  logic             debug_step,
  output logic [2:0]       fwd_a,
  output logic [2:0]       fwd_b,
  output logic             store_fwd_late,
  output logic             if_en,
  output logic             id_en,
  output logic             pipe_en,
  output logic             id_flush,
  output logic             exe_bubble,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int SQ_W = (BR_BUBBLES > 0) ? $clog2(BR_BUBBLES + 1) : 1;
  localparam logic [SQ_W-1:0] SQ_LOAD = SQ_W'(BR_BUBBLES);
  localparam logic [2:0] LP      = 3'(LOAD_POS);
  localparam logic [2:0] LP_LATE = 3'(LOAD_POS - 1);
  localparam bit SLF = (STORE_LATE_FWD != 0);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} dbg_t;

  logic          tv [1:DEPTH];
  logic [AW-1:0] ta [1:DEPTH];
  logic          tl [1:DEPTH];

  logic [SQ_W-1:0] sq;
  dbg_t state, state_nx;
  logic step_prev, halt, freeze;

  logic hit_a, hit_b, ld_a, ld_b;
  logic [2:0] k_a, k_b;
  logic use_a, use_b, stall_a, stall_b, late_b, push;

  // Scan oldest-to-youngest so the youngest producer wins.
  always_comb begin
    hit_a = 1'b0;
    ld_a  = 1'b0;
    k_a   = '0;
    hit_b = 1'b0;
    ld_b  = 1'b0;
    k_b   = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (tv[k] && ta[k] == id_rs_addr) begin
        hit_a = 1'b1;
        ld_a  = tl[k];
        k_a   = 3'(k);
      end
      if (tv[k] && ta[k] == id_rt_addr) begin
        hit_b = 1'b1;
        ld_b  = tl[k];
        k_b   = 3'(k);
      end
    end
  end

  assign use_a   = id_rs_used && (id_rs_addr != '0) && hit_a;
  assign use_b   = id_rt_used && (id_rt_addr != '0) && hit_b;
  assign stall_a = use_a && ld_a && (k_a < LP);
  assign late_b  = use_b && ld_b && id_is_store && SLF
                   && (k_b == LP_LATE);
  assign stall_b = use_b && ld_b && (k_b < LP) && !late_b;

  assign fwd_a = (use_a && !stall_a) ? k_a : 3'd0;
  assign fwd_b = (use_b && !stall_b && !late_b) ? k_b : 3'd0;
  assign store_fwd_late = late_b && id_valid;
  assign hazard_stall   = (stall_a || stall_b) && id_valid;
  assign id_flush       = (sq != '0);
  assign push = id_valid && id_wen && (id_waddr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RUN;
      step_prev <= 1'b0;
    end else begin
      state     <= state_nx;
      step_prev <= debug_step;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_RUN:  if (debug_en) state_nx = S_HALT;
      S_HALT: begin
        if (!debug_en)
          state_nx = S_RUN;
        else if (debug_step && !step_prev)
          state_nx = S_STEP;
      end
      S_STEP: state_nx = debug_en ? S_HALT : S_RUN;
      default: state_nx = S_RUN;
    endcase
  end

  always_comb halt = (state == S_HALT);

  assign freeze = rst || halt;

  always_comb begin
    if_en      = 1'b0;
    id_en      = 1'b0;
    pipe_en    = 1'b0;
    exe_bubble = 1'b0;
    priority case (1'b1)
      freeze:    ;
      ext_stall: ;
      hazard_stall: begin
        pipe_en    = 1'b1;
        exe_bubble = 1'b1;
      end
      default: begin
        if_en   = 1'b1;
        id_en   = 1'b1;
        pipe_en = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        tv[k] <= 1'b0;
        ta[k] <= '0;
        tl[k] <= 1'b0;
      end
    end else if (pipe_en) begin
      for (int k = DEPTH; k >= 2; k--) begin
        tv[k] <= tv[k-1];
        ta[k] <= ta[k-1];
        tl[k] <= tl[k-1];
      end
      tv[1] <= push && !exe_bubble && !id_flush;
      ta[1] <= id_waddr;
      tl[1] <= id_is_load;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq        <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (id_en && branch_taken && id_valid)
        sq <= SQ_LOAD;
      else if (id_en && sq != '0)
        sq <= sq - SQ_W'(1);
      if (hazard_stall && !halt && !ext_stall && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (id_flush && id_en && !(&flush_cnt))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
